aux_slot_host: RTL and testbench



---
 rtl/aux_slot_host.sv | 159 +++++++++++++++
 tb/tb_aux_slot_host.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aux_slot_host.sv
// Host-side Apple IIe aux-slot driver: 14M-derived timing generator, DRAM address mux,
// and a request port that runs one CPU read or write per PHI0 half against the slot card.
module aux_slot_host (
    input  logic        C14M,
    input  logic        RST,
    input  logic        REQ,
    input  logic        REQWE,
    input  logic [15:0] REQA,
    input  logic [7:0]  REQD,
    input  logic        REQAUX,
    input  logic [15:0] VADDR,
    output logic        READY,
    output logic        DONE,
    output logic [7:0]  RDATA,
    output logic [7:0]  VDATA,
    output logic        VSTB,
    output logic        C7M,
    output logic        Q3,
    output logic        PHI0,
    output logic        PHI1,
    output logic        nPRAS,
    output logic        nPCAS,
    output logic        nWE,
    output logic        nWE80,
    output logic        nEN80,
    output logic        nC07X,
    output logic [7:0]  MA,
    inout  logic [7:0]  MD,
    input  logic [7:0]  VD
);

    typedef enum logic [1:0] {
        OP_NONE,
        OP_READ,
        OP_WRITE
    } op_t;

    logic [3:0]  p, p_next, p_last;
    logic [6:0]  k, k_next;
    logic        cyc_end, acc_edge, load_edge, ph0_n;

    op_t         pend_op, act_op, act_op_n;
    logic        pend_aux, act_aux, act_aux_n;
    logic [15:0] pend_a, act_a, act_a_n;
    logic [7:0]  pend_d, act_d, act_d_n;
    logic [7:0]  ma_n;

    logic        md_oe;
    logic [7:0]  md_out;

    assign MD = md_oe ? md_out : 'z;

    // Every output register is loaded from next-state values so it lines up with P itself.
    always_comb begin
        p_last    = (k == 7'd64) ? 4'd15 : 4'd13;
        cyc_end   = (p == p_last);
        p_next    = cyc_end ? '0 : p + 4'd1;
        k_next    = k;
        if (cyc_end) begin
            k_next = (k == 7'd64) ? '0 : k + 7'd1;
        end
        acc_edge  = (p_next == p_last);
        load_edge = (p_next == 4'd7);
        ph0_n     = (p_next >= 4'd7);

        act_op_n  = act_op;
        act_aux_n = act_aux;
        act_a_n   = act_a;
        act_d_n   = act_d;
        if (load_edge) begin
            act_op_n  = pend_op;
            act_aux_n = pend_aux;
            act_a_n   = pend_a;
            act_d_n   = pend_d;
        end

        ma_n = '0;
        if (!ph0_n) begin
            ma_n = (p_next < 4'd4) ? VADDR[7:0] : VADDR[15:8];
        end else begin
            ma_n = (p_next < 4'd11) ? act_a_n[7:0] : act_a_n[15:8];
        end
    end

    always_ff @(posedge C14M) begin
        if (RST) begin
            p        <= '0;
            k        <= '0;
            C7M      <= 1'b0;
            Q3       <= 1'b0;
            PHI0     <= 1'b0;
            PHI1     <= 1'b1;
            nPRAS    <= 1'b1;
            nPCAS    <= 1'b1;
            nWE      <= 1'b1;
            nWE80    <= 1'b1;
            nEN80    <= 1'b1;
            nC07X    <= 1'b1;
            MA       <= '0;
            md_oe    <= 1'b0;
            md_out   <= '0;
            READY    <= 1'b0;
            DONE     <= 1'b0;
            RDATA    <= '0;
            VDATA    <= '0;
            VSTB     <= 1'b0;
            pend_op  <= OP_NONE;
            pend_aux <= 1'b0;
            pend_a   <= '0;
            pend_d   <= '0;
            act_op   <= OP_NONE;
            act_aux  <= 1'b0;
            act_a    <= '0;
            act_d    <= '0;
        end else begin
            p     <= p_next;
            k     <= k_next;
            C7M   <= ~C7M;
            PHI0  <= ph0_n;
            PHI1  <= ~ph0_n;
            Q3    <= (p_next <= 4'd3) || (p_next >= 4'd7 && p_next <= 4'd10);
            nPRAS <= !((p_next >= 4'd2 && p_next <= 4'd6) || p_next >= 4'd9);
            nPCAS <= !((p_next >= 4'd4 && p_next <= 4'd6) || p_next >= 4'd11);
            MA    <= ma_n;

            nEN80  <= !(act_op_n != OP_NONE && act_aux_n && ph0_n);
            nC07X  <= !(act_op_n != OP_NONE && act_a_n[15:4] == 12'hC07 && ph0_n);
            nWE    <= !(act_op_n == OP_WRITE && p_next >= 4'd9);
            nWE80  <= !(act_op_n == OP_WRITE && p_next >= 4'd9);
            md_oe  <= (act_op_n == OP_WRITE) && (p_next >= 4'd8);
            md_out <= act_d_n;

            VSTB <= (p == 4'd6);
            if (p == 4'd6) begin
                VDATA <= VD;
            end

            // Entering P=L both retires the running access and books the next one, so
            // pending and active copies are kept apart until the next PHI0 half starts.
            READY <= acc_edge && REQ;
            DONE  <= acc_edge && (act_op != OP_NONE);
            if (acc_edge) begin
                pend_op  <= REQ ? (REQWE ? OP_WRITE : OP_READ) : OP_NONE;
                pend_aux <= REQAUX;
                pend_a   <= REQA;
                pend_d   <= REQD;
                if (act_op == OP_READ) begin
                    RDATA <= MD;
                end
            end

            act_op  <= act_op_n;
            act_aux <= act_aux_n;
            act_a   <= act_a_n;
            act_d   <= act_d_n;
        end
    end

endmodule

// File: tb/tb_aux_slot_host.sv
// Directed bench for aux_slot_host: timing free-run, aux writes/reads, C07X decode,
// video capture, reset mid-access and the long-cycle access latency.
module tb_aux_slot_host;

    logic        C14M;
    logic        RST;
    logic        REQ;
    logic        REQWE;
    logic [15:0] REQA;
    logic [7:0]  REQD;
    logic        REQAUX;
    logic [15:0] VADDR;
    logic        READY, DONE, VSTB;
    logic [7:0]  RDATA, VDATA, MA, VD;
    logic        C7M, Q3, PHI0, PHI1, nPRAS, nPCAS, nWE, nWE80, nEN80, nC07X;
    wire  [7:0]  md_bus;

    // Card model: drives read data while selected, latches its bank register on C07X writes.
    logic        card_drive;
    logic [7:0]  rd_val;
    logic [7:0]  bank_reg;
    logic        card_oe;
    logic [7:0]  card_d;
    assign card_oe = card_drive && !nEN80 && PHI0 && nWE80;
    assign card_d  = !nC07X ? bank_reg : rd_val;
    assign md_bus  = card_oe ? card_d : 8'hzz;

    always @(negedge C14M) begin
        if (!nC07X && !nWE80) bank_reg <= md_bus;
    end

    // Reference phase/cycle counters.
    logic [3:0] tp, tl;
    logic [6:0] tk;
    assign tl = (tk == 7'd64) ? 4'd15 : 4'd13;
    always_ff @(posedge C14M) begin
        if (RST) begin
            tp <= '0;
            tk <= '0;
        end else if (tp == tl) begin
            tp <= '0;
            tk <= (tk == 7'd64) ? 7'd0 : tk + 7'd1;
        end else begin
            tp <= tp + 4'd1;
        end
    end

    aux_slot_host dut (
        .C14M(C14M), .RST(RST), .REQ(REQ), .REQWE(REQWE), .REQA(REQA), .REQD(REQD),
        .REQAUX(REQAUX), .VADDR(VADDR), .READY(READY), .DONE(DONE), .RDATA(RDATA),
        .VDATA(VDATA), .VSTB(VSTB), .C7M(C7M), .Q3(Q3), .PHI0(PHI0), .PHI1(PHI1),
        .nPRAS(nPRAS), .nPCAS(nPCAS), .nWE(nWE), .nWE80(nWE80), .nEN80(nEN80),
        .nC07X(nC07X), .MA(MA), .MD(md_bus), .VD(VD)
    );

    initial C14M = 1'b0;
    always #5 C14M = ~C14M;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ma_s[16];
    logic [7:0]  md_s[16];
    logic [15:0] en_s, we_s, we80_s, c07_s, ras_s, cas_s, done_s, ph0_s;
    logic [7:0]  rd_cap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge C14M);
    endtask

    task automatic wait_phase(input int ph, input int kk, input int limit);
        int n = 0;
        while (!(32'(tp) == ph && (kk < 0 || 32'(tk) == kk)) && n < limit) begin
            @(negedge C14M);
            n++;
        end
        chk("wait_phase", 32'(tp), 32'(ph));
    endtask

    task automatic request(input logic we, input logic [15:0] a, input logic [7:0] d,
                           input logic aux);
        REQWE = we; REQA = a; REQD = d; REQAUX = aux; REQ = 1'b1;
        for (int n = 0; n < 60 && READY !== 1'b1; n++) @(negedge C14M);
        chk("ready_seen", 32'(READY), 32'd1);
        chk("ready_phase", 32'(tp), 32'(tl));
        REQ = 1'b0;
    endtask

    // Samples one full cycle after READY; index equals the DUT phase P.
    task automatic capture(input int n);
        en_s = '1; we_s = '1; we80_s = '1; c07_s = '1; ras_s = '1; cas_s = '1;
        done_s = '0; ph0_s = '0; rd_cap = 8'h00;
        for (int i = 0; i < n; i++) begin
            @(negedge C14M);
            ma_s[i] = MA; md_s[i] = md_bus;
            en_s[i] = nEN80; we_s[i] = nWE; we80_s[i] = nWE80; c07_s[i] = nC07X;
            ras_s[i] = nPRAS; cas_s[i] = nPCAS; done_s[i] = DONE; ph0_s[i] = PHI0;
            if (DONE) rd_cap = RDATA;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, run, first_long, second_long, short_bad, shorts_between, md_hits, n, rdy, dn, ph7;
        RST = 1'b1; REQ = 1'b0; REQWE = 1'b0; REQA = '0; REQD = '0; REQAUX = 1'b0;
        VADDR = 16'hBEEF; VD = 8'h00; card_drive = 1'b0; rd_val = 8'h00; bank_reg = 8'h00;

        tick(3);
        chk("rst_clocks", 32'({C7M, Q3, PHI0, PHI1, nPRAS, nPCAS, nWE, nWE80, nEN80, nC07X}),
            32'b0001111111);
        chk("rst_data", {MA, RDATA, VDATA, 8'(md_bus)}, 32'h0);
        chk("rst_flags", 32'({READY, DONE, VSTB}), 32'd0);
        RST = 1'b0;
        @(negedge C14M);
        chk("p1_clocks", 32'({C7M, Q3, PHI0, PHI1, nPRAS, nPCAS}), 32'b110111);

        // Free-run: measure PHI0 high runs and the distance between long cycles.
        t = 1; run = 0; first_long = -1; second_long = -1; short_bad = 0; shorts_between = 0;
        for (int i = 0; i < 2200 && second_long < 0; i++) begin
            @(negedge C14M);
            t++;
            if (PHI0) run++;
            else if (run > 0) begin
                if (run == 9) begin
                    if (first_long < 0) first_long = t; else second_long = t;
                end else begin
                    if (run != 7) short_bad++;
                    if (first_long >= 0) shorts_between++;
                end
                run = 0;
            end
        end
        chk("first_long_end", 32'(first_long), 32'd912);
        chk("k_wrap_period", 32'(second_long - first_long), 32'd912);
        chk("short_cycles", 32'(shorts_between), 32'd64);
        chk("short_phi0_len", 32'(short_bad), 32'd0);

        // Aux write 0x1234 <- 0xA5.
        request(1'b1, 16'h1234, 8'hA5, 1'b1);
        capture(14);
        chk("wr_ma_vrow", 32'(ma_s[2]), 32'hEF);
        chk("wr_ma_vcol", 32'(ma_s[5]), 32'hBE);
        chk("wr_ma_row", 32'(ma_s[10]), 32'h34);
        chk("wr_ma_col", 32'(ma_s[11]), 32'h12);
        chk("wr_nen80_low", 32'(16 - $countones(en_s)), 32'd7);
        chk("wr_nwe_low", 32'(16 - $countones(we_s)), 32'd5);
        chk("wr_nwe80_low", 32'(16 - $countones(we80_s)), 32'd5);
        chk("wr_nwe_edge", 32'(we_s[9:8]), 32'b01);
        chk("wr_nc07x_low", 32'(16 - $countones(c07_s)), 32'd0);
        chk("wr_ras_low", 32'(16 - $countones(ras_s)), 32'd10);
        chk("wr_cas_low", 32'(16 - $countones(cas_s)), 32'd6);
        md_hits = 0;
        for (int i = 8; i < 14; i++) if (md_s[i] === 8'hA5) md_hits++;
        chk("wr_md_driven", 32'(md_hits), 32'd6);
        chk("wr_done", 32'(done_s), 32'h2000);

        // Aux read with the card returning 0x5A.
        card_drive = 1'b1; rd_val = 8'h5A;
        request(1'b0, 16'h0200, 8'hFF, 1'b1);
        capture(14);
        chk("rd_done", 32'(done_s), 32'h2000);
        chk("rd_data", 32'(rd_cap), 32'h5A);
        chk("rd_bus", 32'(md_s[10]), 32'h5A);
        chk("rd_nwe_low", 32'(16 - $countones(we_s)), 32'd0);
        card_drive = 1'b0;

        // Bank register write through C07X, then read it back.
        request(1'b1, 16'hC073, 8'h03, 1'b1);
        capture(14);
        chk("c07_nc07x_low", 32'(16 - $countones(c07_s)), 32'd7);
        chk("c07_nen80_low", 32'(16 - $countones(en_s)), 32'd7);
        chk("c07_done", 32'(done_s), 32'h2000);
        card_drive = 1'b1; rd_val = 8'hEE;
        request(1'b0, 16'hC073, 8'h00, 1'b1);
        capture(14);
        chk("c07_readback", 32'(rd_cap), 32'h03);
        card_drive = 1'b0;

        // Video capture.
        VD = 8'hC3;
        wait_phase(0, -1, 20);
        for (n = 0; n < 20 && VSTB !== 1'b1; n++) @(negedge C14M);
        chk("vstb_seen", 32'(VSTB), 32'd1);
        chk("vstb_phase", 32'(tp), 32'd7);
        chk("vdata", 32'(VDATA), 32'hC3);
        @(negedge C14M);
        chk("vstb_pulse", 32'(VSTB), 32'd0);

        // REQ outside P=L is ignored.
        wait_phase(3, -1, 20);
        REQ = 1'b1; REQWE = 1'b1; REQAUX = 1'b1;
        @(negedge C14M);
        REQ = 1'b0;
        rdy = 0; dn = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge C14M);
            if (READY) rdy++;
            if (DONE) dn++;
        end
        chk("req_ignored", 32'(rdy + dn), 32'd0);

        // Reset during a write at P=10.
        request(1'b1, 16'h1234, 8'hA5, 1'b1);
        wait_phase(10, -1, 20);
        chk("pre_rst_md", 32'(md_bus), 32'hA5);
        RST = 1'b1;
        @(negedge C14M);
        chk("rst_strobes", 32'({nPRAS, nPCAS, nWE, nWE80, nEN80, nC07X}), 32'h3F);
        chk("rst_md_released", 32'(md_bus === 8'hA5), 32'd0);
        chk("rst_no_done", 32'(DONE), 32'd0);
        @(negedge C14M);
        RST = 1'b0;
        ph7 = -1; dn = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge C14M);
            if (PHI0 && ph7 < 0) ph7 = i;
            if (DONE) dn++;
        end
        chk("rst_restart_phi0", 32'(ph7), 32'd7);
        chk("rst_abandoned", 32'(dn), 32'd0);

        // Request accepted just before the long cycle: DONE 16 clocks after READY.
        wait_phase(2, 63, 1100);
        request(1'b1, 16'h5678, 8'h99, 1'b0);
        capture(16);
        chk("long_done", 32'(done_s), 32'h8000);
        chk("long_phi0_len", 32'($countones(ph0_s)), 32'd9);
        chk("long_nwe_low", 32'(16 - $countones(we_s)), 32'd7);
        chk("long_ras_low", 32'(16 - $countones(ras_s)), 32'd12);
        chk("long_ma_col", 32'(ma_s[15]), 32'h56);
        chk("long_md", 32'(md_s[15]), 32'h99);
        chk("long_nen80_low", 32'(16 - $countones(en_s)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
